mc_ctrl_fsm: RTL and testbench

//  Main control FSM of the multi-cycle MIPS core; sequences the shared ALU/memory datapath per instruction.

---
 rtl/mc_pkg.sv | 45 ++++
 rtl/mc_ctrl_outdec.sv | 93 +++++++++
 rtl/mc_ctrl_fsm.sv | 110 +++++++++++
 tb/tb_mc_ctrl_fsm.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control path.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemadr, StMemrd, StMemwb, StMemwr,
        StRtypeex, StRtypewb, StBeqex, StImmex, StImmwb, StJex
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_XOR   = 3'b101;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    function automatic logic [2:0] imm_aluop(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALUOP_AND;
            OP_ORI:  return ALUOP_OR;
            OP_XORI: return ALUOP_XOR;
            default: return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational decode of FSM state (plus mem_ready/zero) into datapath controls.
module mc_ctrl_outdec
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic       mem_rdy,
    input  logic       zero,
    input  logic       is_bne,
    output logic       mem_req,
    output logic       memwrite,
    output logic       irwrite,
    output logic       iord,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic [2:0] aluop,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg
);

    always_comb begin
        mem_req  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        iord     = 1'b0;
        pcen     = 1'b0;
        pcsrc    = PCSRC_ALURES;
        alusrca  = 1'b0;
        alusrcb  = SRCB_B;
        zeroext  = 1'b0;
        aluop    = ALUOP_ADD;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        case (state)
            StFetch: begin
                mem_req = 1'b1;
                alusrcb = SRCB_FOUR;
                irwrite = mem_rdy;
                pcen    = mem_rdy;
            end
            StDecode: alusrcb = SRCB_IMMSH;
            StMemadr: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            StMemrd: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            StMemwb: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            StMemwr: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            StRtypeex: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            StRtypewb: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            StBeqex: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                pcen    = zero ^ is_bne;
            end
            StImmex: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluop   = imm_aluop(op);
                zeroext = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
            end
            StImmwb: regwrite = 1'b1;
            StJex: begin
                pcsrc = PCSRC_JUMP;
                pcen  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS core.
// Define MC_CTRL_BNE_EN to decode BNE through the branch-execute state.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int unsigned MEM_HANDSHAKE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       irwrite,
    output logic       iord,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic [2:0] aluop,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       illegal_op
);

    state_t state_q, state_d;
    logic   mem_rdy;
    logic   op_legal;
    logic   is_bne_q;

    assign mem_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    always_comb begin
        state_d  = state_q;
        op_legal = 1'b1;
        case (state_q)
            StFetch:  if (mem_rdy) state_d = StDecode;
            StDecode: begin
                case (op)
                    OP_RTYPE:                            state_d = StRtypeex;
                    OP_LW, OP_SW:                        state_d = StMemadr;
                    OP_BEQ:                              state_d = StBeqex;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:                              state_d = StBeqex;
`endif
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI:   state_d = StImmex;
                    OP_J:                                state_d = StJex;
                    default: begin
                        state_d  = StFetch;
                        op_legal = 1'b0;
                    end
                endcase
            end
            StMemadr:  state_d = (op == OP_LW) ? StMemrd : StMemwr;
            StMemrd:   if (mem_rdy) state_d = StMemwb;
            StMemwr:   if (mem_rdy) state_d = StFetch;
            StRtypeex: state_d = StRtypewb;
            StImmex:   state_d = StImmwb;
            default:   state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            illegal_op <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode && !op_legal) illegal_op <= 1'b1;
        end
    end

`ifdef MC_CTRL_BNE_EN
    // Captured while op is still the branch being decoded; used to invert the taken test.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_bne_q <= 1'b0;
        end else if (state_q == StDecode) begin
            is_bne_q <= (op == OP_BNE);
        end
    end
`else
    assign is_bne_q = 1'b0;
`endif

    mc_ctrl_outdec u_outdec (
        .state    (state_q),
        .op       (op),
        .mem_rdy  (mem_rdy),
        .zero     (zero),
        .is_bne   (is_bne_q),
        .mem_req  (mem_req),
        .memwrite (memwrite),
        .irwrite  (irwrite),
        .iord     (iord),
        .pcen     (pcen),
        .pcsrc    (pcsrc),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .zeroext  (zeroext),
        .aluop    (aluop),
        .regwrite (regwrite),
        .regdst   (regdst),
        .memtoreg (memtoreg)
    );

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench: per-instruction cycle model pushes expected controls, monitor compares.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, memwrite, irwrite, iord, pcen, alusrca, zeroext;
    logic       regwrite, regdst, memtoreg, illegal_op;
    logic [1:0] pcsrc, alusrcb;
    logic [2:0] aluop;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .iord       (iord),
        .pcen       (pcen),
        .pcsrc      (pcsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .zeroext    (zeroext),
        .aluop      (aluop),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .illegal_op (illegal_op)
    );

    typedef struct packed {
        logic       mem_req, memwrite, irwrite, iord, pcen;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [2:0] aluop;
        logic       regwrite, regdst, memtoreg, illegal_op;
    } exp_t;

    typedef struct {
        exp_t  e;
        string tag;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   ill = 1'b0;

    always @(negedge clk) begin
        ent_t x;
        exp_t act;
        if (sb.size() > 0) begin
            x   = sb.pop_front();
            act = {mem_req, memwrite, irwrite, iord, pcen, pcsrc, alusrca, alusrcb, zeroext,
                   aluop, regwrite, regdst, memtoreg, illegal_op};
            checks++;
            if (act !== x.e) begin
                errors++;
                $display("FAIL %s: got %b required %b (t=%0t)", x.tag, act, x.e, $time);
            end
        end
    end

    function automatic exp_t blank();
        exp_t r;
        r = '0;
        r.illegal_op = ill;
        return r;
    endfunction

    task automatic step(input logic mr, input exp_t e, input string tag);
        mem_ready = mr;
        sb.push_back('{e, tag});
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input int fw);
        exp_t e;
        for (int i = 0; i < fw; i++) begin
            e = blank(); e.mem_req = 1; e.alusrcb = 2'b01;
            step(1'b0, e, "fetch_wait");
        end
        e = blank(); e.mem_req = 1; e.alusrcb = 2'b01; e.irwrite = 1; e.pcen = 1;
        step(1'b1, e, "fetch_done");
        e = blank(); e.alusrcb = 2'b11;
        step(1'($urandom_range(0, 1)), e, "decode");
    endtask

    // One instruction: fw fetch wait cycles, mw data-memory wait cycles.
    task automatic instr(input logic [5:0] o, input logic z, input int fw, input int mw);
        exp_t e;
        bit   is_br;
        bit   inv;
        op   = o;
        zero = z;
        do_fetch(fw);
        is_br = (o == 6'b000100);
        inv   = 1'b0;
`ifdef MC_CTRL_BNE_EN
        if (o == 6'b000101) begin
            is_br = 1'b1;
            inv   = 1'b1;
        end
`endif
        if (is_br) begin
            e = blank(); e.alusrca = 1; e.aluop = 3'b001; e.pcsrc = 2'b01; e.pcen = z ^ inv;
            step(1'($urandom_range(0, 1)), e, "branch_ex");
        end else begin
            case (o)
                6'b000000: begin
                    e = blank(); e.alusrca = 1; e.aluop = 3'b010;
                    step(1'($urandom_range(0, 1)), e, "rtype_ex");
                    e = blank(); e.regwrite = 1; e.regdst = 1;
                    step(1'($urandom_range(0, 1)), e, "rtype_wb");
                end
                6'b100011, 6'b101011: begin
                    e = blank(); e.alusrca = 1; e.alusrcb = 2'b10;
                    step(1'($urandom_range(0, 1)), e, "mem_adr");
                    e = blank(); e.mem_req = 1; e.iord = 1; e.memwrite = (o == 6'b101011);
                    for (int i = 0; i < mw; i++) step(1'b0, e, "mem_wait");
                    step(1'b1, e, "mem_done");
                    if (o == 6'b100011) begin
                        e = blank(); e.regwrite = 1; e.memtoreg = 1;
                        step(1'($urandom_range(0, 1)), e, "lw_wb");
                    end
                end
                6'b001000, 6'b001100, 6'b001101, 6'b001110: begin
                    e = blank(); e.alusrca = 1; e.alusrcb = 2'b10;
                    e.zeroext = (o != 6'b001000);
                    e.aluop = (o == 6'b001100) ? 3'b011 :
                              (o == 6'b001101) ? 3'b100 :
                              (o == 6'b001110) ? 3'b101 : 3'b000;
                    step(1'($urandom_range(0, 1)), e, "imm_ex");
                    e = blank(); e.regwrite = 1;
                    step(1'($urandom_range(0, 1)), e, "imm_wb");
                end
                6'b000010: begin
                    e = blank(); e.pcsrc = 2'b10; e.pcen = 1;
                    step(1'($urandom_range(0, 1)), e, "jump_ex");
                end
                default: ill = 1'b1;
            endcase
        end
    endtask

    logic [5:0] optab [12];

    initial begin
        exp_t e;
        optab = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h02,
                  6'h3f, 6'h01};
        reset = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        e = blank(); e.mem_req = 1; e.alusrcb = 2'b01;
        step(1'b0, e, "reset_state");
        reset = 1'b0;

        instr(6'b100011, 1'b0, 0, 0);  // LW, no waits
        instr(6'b101011, 1'b0, 1, 3);  // SW, 3 waits in MEMWR
        instr(6'b000100, 1'b1, 0, 0);  // BEQ taken
        instr(6'b000100, 1'b0, 0, 0);  // BEQ not taken
        instr(6'b001101, 1'b0, 0, 0);  // ORI
        instr(6'b000010, 1'b0, 0, 0);  // J
        instr(6'b000000, 1'b0, 2, 0);  // R-type
        instr(6'b001000, 1'b0, 0, 0);  // ADDI
        instr(6'b001100, 1'b0, 0, 0);  // ANDI
        instr(6'b001110, 1'b0, 0, 0);  // XORI
        instr(6'b111111, 1'b0, 0, 0);  // illegal
        instr(6'b000101, 1'b0, 0, 0);  // BNE
        instr(6'b100011, 1'b1, 1, 2);  // LW with waits, illegal_op still set

        for (int n = 0; n < 60; n++)
            instr(optab[$urandom_range(0, 11)], 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), $urandom_range(0, 3));

        // Reset while LW waits in MEMRD: access dropped, sticky flag cleared.
        if (!ill) instr(6'b111111, 1'b0, 0, 0);
        op = 6'b100011;
        do_fetch(0);
        e = blank(); e.alusrca = 1; e.alusrcb = 2'b10;
        step(1'b0, e, "mem_adr");
        reset = 1'b1;
        e = blank(); e.mem_req = 1; e.iord = 1;
        step(1'b0, e, "memrd_in_reset");
        reset = 1'b0;
        ill = 1'b0;
        instr(6'b000000, 1'b0, 2, 0);
        instr(6'b101011, 1'b0, 0, 1);

        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
